// File: rtl/i2c_master_byte.sv
// i2c_master_byte: single-byte I2C master (one write or one read per request).
//
// Ports:
//   i_clk, i_rstn         system clock, asynchronous active-low reset
//   i_start               one-cycle request, sampled only while o_busy=0
//   i_rw                  0=write, 1=read (captured with i_start)
//   i_addr[6:0]           7-bit slave address (captured with i_start)
//   i_wdata[7:0]          write byte (captured with i_start)
//   o_busy                high from the cycle after capture until o_done
//   o_done                one-cycle pulse at the end of every transaction
//   o_ack_err             1 = address or write data NACKed; held until next start
//   o_rdata[7:0]          read byte, updated at o_done of a successful read
//   o_scl_oe, o_sda_oe    1 = pull the pad low, 0 = release
//   i_scl_in, i_sda_in    pad levels (asynchronous, synchronised here)
//
// Every bit cell is four quarters of CLK_DIV cycles:
//   Q0 SCL low + SDA driven, Q1 SCL low, Q2 SCL released, Q3 SCL high (SDA sampled).
// The quarter that follows a release of SCL cannot end while the synchronised
// SCL still reads low, which implements slave clock stretching. CLK_DIV must lie
// in 2..1023; for CLK_DIV>=3 an unstretched write or read takes exactly
// 77*CLK_DIV+1 cycles from capture to o_done (at CLK_DIV=2 the synchroniser
// latency adds one cycle per released-SCL quarter).
module i2c_master_byte #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic [7:0] o_rdata,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    input  logic       i_scl_in,
    input  logic       i_sda_in
);

    localparam int unsigned QW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        S_IDLE,
        S_STA,
        S_ADDR,
        S_AACK,
        S_WDAT,
        S_WACK,
        S_RDAT,
        S_RNAK,
        S_STP,
        S_DONE
    } state_t;

    // Registered state
    state_t        r_state;
    logic [1:0]    r_q;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic          r_rw;
    logic [7:0]    r_wdata;
    logic [QW-1:0] r_qcnt;
    logic          r_busy;
    logic          r_done;
    logic          r_ack_err;
    logic [7:0]    r_rdata;
    logic          r_scl_oe;
    logic          r_sda_oe;
    logic          r_scl_s1;
    logic          r_scl_s2;
    logic          r_sda_s1;
    logic          r_sda_s2;

    // Next-state values
    state_t        w_state_nxt;
    logic [1:0]    w_q_nxt;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    w_sh_nxt;
    logic          w_rw_nxt;
    logic [7:0]    w_wdata_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic          w_ack_err_nxt;
    logic [7:0]    w_rdata_nxt;
    logic [1:0]    w_drv_nxt;
    logic          w_capture;
    logic          w_hold;
    logic          w_qterm;
    logic          w_tick;
    logic          w_q3_tick;

    // Pad input synchronisers; reset to the idle (high) bus level
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= i_scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= i_sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Quarter timing: the terminal count is held while SCL is released but still low
    assign w_capture = (r_state == S_IDLE) && i_start;
    assign w_hold    = !r_scl_oe && !r_scl_s2;
    assign w_qterm   = (r_qcnt == QW'(CLK_DIV - 1));
    assign w_tick    = r_busy && w_qterm && !w_hold;
    assign w_q3_tick = w_tick && (r_q == 2'd3);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_qcnt <= '0;
        end else if (w_capture) begin
            r_qcnt <= '0;
        end else if (r_busy) begin
            if (!w_qterm) begin
                r_qcnt <= r_qcnt + QW'(1);
            end else if (!w_hold) begin
                r_qcnt <= '0;
            end
        end
    end

    // Pad drive {scl_oe, sda_oe} for a given state/quarter/transmit bit
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q, input logic b);
        logic [1:0] drv;
        drv = 2'b00;
        case (st)
            S_STA:                         drv = {1'b0, (q == 2'd1)};
            S_ADDR, S_WDAT:                drv = {!q[1], !b};
            S_AACK, S_WACK, S_RDAT, S_RNAK: drv = {!q[1], 1'b0};
            S_STP:                         drv = {(q == 2'd0), (q != 2'd2)};
            default:                       drv = 2'b00;
        endcase
        return drv;
    endfunction

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_bit_nxt     = r_bit;
        w_sh_nxt      = r_sh;
        w_rw_nxt      = r_rw;
        w_wdata_nxt   = r_wdata;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ack_err_nxt = r_ack_err;
        w_rdata_nxt   = r_rdata;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_STA;
                    w_q_nxt       = 2'd0;
                    w_bit_nxt     = 3'd0;
                    w_sh_nxt      = {i_addr, i_rw};
                    w_rw_nxt      = i_rw;
                    w_wdata_nxt   = i_wdata;
                    w_busy_nxt    = 1'b1;
                    w_ack_err_nxt = 1'b0;
                end
            end

            S_STA: begin
                if (w_tick) begin
                    if (r_q == 2'd1) begin
                        w_state_nxt = S_ADDR;
                        w_q_nxt     = 2'd0;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_q_nxt = r_q + 2'd1;
                    end
                end
            end

            S_ADDR, S_WDAT: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                end
                if (w_q3_tick) begin
                    w_sh_nxt  = {r_sh[6:0], 1'b0};
                    w_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = (r_state == S_ADDR) ? S_AACK : S_WACK;
                    end
                end
            end

            S_AACK: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                end
                if (w_q3_tick) begin
                    w_bit_nxt = 3'd0;
                    if (r_sda_s2) begin
                        w_ack_err_nxt = 1'b1;
                        w_state_nxt   = S_STP;
                    end else if (r_rw) begin
                        w_state_nxt = S_RDAT;
                    end else begin
                        w_state_nxt = S_WDAT;
                        w_sh_nxt    = r_wdata;
                    end
                end
            end

            S_WACK: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                end
                if (w_q3_tick) begin
                    if (r_sda_s2) begin
                        w_ack_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_STP;
                end
            end

            S_RDAT: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                end
                if (w_q3_tick) begin
                    w_sh_nxt  = {r_sh[6:0], r_sda_s2};
                    w_bit_nxt = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_RNAK;
                    end
                end
            end

            S_RNAK: begin
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                end
                if (w_q3_tick) begin
                    w_state_nxt = S_STP;
                end
            end

            // SDA low under low SCL, then SCL high, then SDA high (STOP)
            S_STP: begin
                if (w_tick) begin
                    if (r_q == 2'd2) begin
                        w_state_nxt = S_DONE;
                        w_q_nxt     = 2'd0;
                    end else begin
                        w_q_nxt = r_q + 2'd1;
                    end
                end
            end

            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                w_q_nxt     = 2'd0;
                if (r_rw && !r_ack_err) begin
                    w_rdata_nxt = r_sh;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Pad drive follows the state being entered so it changes on the same edge
        w_drv_nxt = bus_drive(w_state_nxt, w_q_nxt, w_sh_nxt[7]);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_sh      <= 8'h00;
            r_rw      <= 1'b0;
            r_wdata   <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'h00;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_bit     <= w_bit_nxt;
            r_sh      <= w_sh_nxt;
            r_rw      <= w_rw_nxt;
            r_wdata   <= w_wdata_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ack_err <= w_ack_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_scl_oe  <= w_drv_nxt[1];
            r_sda_oe  <= w_drv_nxt[0];
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_ack_err = r_ack_err;
    assign o_rdata   = r_rdata;
    assign o_scl_oe  = r_scl_oe;
    assign o_sda_oe  = r_sda_oe;

endmodule
